fp_adder_sequencer: RTL and testbench

FP_ADDER_SEQUENCER -- requirements
Module: fp_adder_sequencer

---
 rtl/fp_adder_sequencer.sv | 116 +++++++++++
 tb/tb_fp_adder_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_sequencer.sv
// fp_adder_sequencer: AXI4-Lite register front end that launches one FP add and collects its result
module fp_adder_sequencer #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int TIMEOUT_CYCLES     = 64
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     fpa_a,
    output logic [31:0]                     fpa_b,
    output logic                            fpa_start,
    input  logic [31:0]                     fpa_result,
    input  logic                            fpa_valid,
    output logic                            irq
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t state, state_nx;
    logic [31:0] op_a, op_b, result;
    logic [15:0] cnt;
    logic irq_en, done, timeout, busy, wr_en, rd_en, start_acc, fin_ok, fin_to;
    logic [1:0] wsel, rsel;
    logic unused;
    assign unused = &{1'b0, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign wsel = s00_axi_awaddr[3:2];
    assign rsel = s00_axi_araddr[3:2];
    assign wr_en = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en = s00_axi_arready & s00_axi_arvalid;
    assign busy = state != IDLE;
    assign start_acc = wr_en & (wsel == 2'd2) & s00_axi_wdata[0] & (state == IDLE);
    assign fin_ok = (state == WAIT) & fpa_valid;
    assign fin_to = (state == WAIT) & ~fpa_valid & (cnt == LAST);
    assign s00_axi_wready = s00_axi_awready;
    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;
    // state register
    always_ff @(posedge s00_axi_aclk)
        state <= s00_axi_areset ? IDLE : state_nx;
    // next-state decode and the one-cycle launch pulse
    always_comb begin
        state_nx = state;
        fpa_start = 1'b0;
        case (state)
            IDLE:    state_nx = start_acc ? LAUNCH : IDLE;
            LAUNCH: begin
                fpa_start = 1'b1;
                state_nx = WAIT;
            end
            WAIT:    state_nx = (fin_ok || fin_to) ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // bus handshakes, register file, operand capture, completion status and irq
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            s00_axi_awready <= 1'b0;
            s00_axi_bvalid <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata <= '0;
            op_a <= '0;
            op_b <= '0;
            result <= '0;
            fpa_a <= '0;
            fpa_b <= '0;
            irq_en <= 1'b0;
            done <= 1'b0;
            timeout <= 1'b0;
            cnt <= '0;
            irq <= 1'b0;
        end else begin
            s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
            s00_axi_bvalid <= wr_en ? 1'b1 : (s00_axi_bready ? 1'b0 : s00_axi_bvalid);
            s00_axi_arready <= s00_axi_arvalid & ~s00_axi_rvalid & ~s00_axi_arready;
            s00_axi_rvalid <= rd_en ? 1'b1 : (s00_axi_rready ? 1'b0 : s00_axi_rvalid);
            if (rd_en)
                s00_axi_rdata <= rsel == 2'd0 ? op_a : rsel == 2'd1 ? op_b :
                                 rsel == 2'd2 ? {28'b0, irq_en, timeout, done, busy} : result;
            for (int i = 0; i < 4; i++) begin
                if (wr_en && wsel == 2'd0 && s00_axi_wstrb[i]) op_a[8*i +: 8] <= s00_axi_wdata[8*i +: 8];
                if (wr_en && wsel == 2'd1 && s00_axi_wstrb[i]) op_b[8*i +: 8] <= s00_axi_wdata[8*i +: 8];
            end
            if (wr_en && wsel == 2'd2) irq_en <= s00_axi_wdata[1];
            if (start_acc) begin
                fpa_a <= op_a;
                fpa_b <= op_b;
                done <= 1'b0;
                timeout <= 1'b0;
            end
            cnt <= state == LAUNCH ? 16'd0 : state == WAIT ? cnt + 16'd1 : cnt;
            if (fin_ok) begin
                result <= fpa_result;
                done <= 1'b1;
            end
            if (fin_to) timeout <= 1'b1;
            irq <= irq_en & (done | timeout);
        end
    end
endmodule

// File: tb/tb_fp_adder_sequencer.sv
// tb_fp_adder_sequencer: directed register-level checks with a latency-programmable adder core model
module tb_fp_adder_sequencer;
    logic clk = 0, rst = 1;
    logic [3:0] awaddr = 0, araddr = 0, wstrb = 0;
    logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic arvalid = 0, arready, rvalid, rready = 0;
    logic [1:0] bresp, rresp;
    logic [31:0] wdata = 0, rdata, fpa_a, fpa_b, fpa_result;
    logic fpa_start, fpa_valid, irq;
    logic core_en = 0;
    int core_lat = 5;
    logic [31:0] core_res = 0, last_a = 0, last_b = 0, rd;
    int starts = 0, total = 0, bad = 0;
    logic held;

    fp_adder_sequencer dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_start(fpa_start),
        .fpa_result(fpa_result), .fpa_valid(fpa_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    // launch monitor: count pulses and capture the operands presented with them
    always @(negedge clk) begin
        if (fpa_start) begin
            starts <= starts + 1;
            last_a <= fpa_a;
            last_b <= fpa_b;
        end
    end

    // adder core model: answers core_lat cycles after a launch when enabled
    initial begin
        fpa_valid = 0;
        fpa_result = 0;
        forever begin
            @(negedge clk);
            if (fpa_start && core_en) begin
                repeat (core_lat) @(negedge clk);
                fpa_result = core_res;
                fpa_valid = 1;
                @(negedge clk);
                fpa_valid = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        if (n == 20) chk("awready_timeout", 0, 1);
        chk("wready_with_awready", wready, awready);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; bready = 1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (n == 20) chk("bvalid_timeout", 0, 1);
        chk("bresp", bresp, 0);
        @(posedge clk); #1;
        bready = 0;
    endtask

    task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (n == 20) chk("arready_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 0; rready = 1;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (n == 20) chk("rvalid_timeout", 0, 1);
        d = rdata;
        chk("rresp", rresp, 0);
        @(posedge clk); #1;
        rready = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_fpa_start", fpa_start, 0);
        chk("rst_fpa_a", fpa_a, 0);
        rst = 0;
        axi_rd(4'h8, rd); chk("rst_ctrl", rd, 0);
        axi_rd(4'hC, rd); chk("rst_result", rd, 0);

        core_en = 1; core_lat = 5; core_res = 32'h40400000;
        axi_wr(4'h0, 32'h3F800000, 4'hF);
        axi_wr(4'h4, 32'h40000000, 4'hF);
        axi_wr(4'h8, 32'h1, 4'hF);
        repeat (20) @(negedge clk);
        chk("add_starts", starts, 1);
        chk("add_fpa_a", last_a, 32'h3F800000);
        chk("add_fpa_b", last_b, 32'h40000000);
        axi_rd(4'h8, rd); chk("add_ctrl", rd, 32'h2);
        axi_rd(4'hC, rd); chk("add_result", rd, 32'h40400000);
        chk("add_irq", irq, 0);

        core_lat = 30; core_res = 32'h11111111;
        axi_wr(4'h0, 32'h40A00000, 4'hF);
        axi_wr(4'h8, 32'h1, 4'hF);
        axi_rd(4'h8, rd); chk("busy_ctrl", rd, 32'h1);
        axi_wr(4'h0, 32'h12345678, 4'hF);
        axi_wr(4'h8, 32'h1, 4'hF);
        chk("busy_starts", starts, 2);
        chk("busy_fpa_a", fpa_a, 32'h40A00000);
        repeat (40) @(negedge clk);
        chk("busy_starts_end", starts, 2);
        axi_rd(4'h8, rd); chk("busy_done_ctrl", rd, 32'h2);
        axi_rd(4'hC, rd); chk("busy_result", rd, 32'h11111111);

        core_en = 0;
        axi_wr(4'h8, 32'h3, 4'hF);
        repeat (57) @(negedge clk);
        axi_rd(4'h8, rd); chk("to_still_busy", rd, 32'h9);
        repeat (20) @(negedge clk);
        axi_rd(4'h8, rd); chk("to_ctrl", rd, 32'hC);
        chk("to_irq", irq, 1);
        axi_rd(4'hC, rd); chk("to_result_kept", rd, 32'h11111111);
        core_en = 1; core_lat = 5; core_res = 32'h40400000;
        axi_wr(4'h8, 32'h3, 4'hF);
        chk("restart_irq_clr", irq, 0);
        repeat (15) @(negedge clk);
        chk("done_irq", irq, 1);
        axi_rd(4'h8, rd); chk("done_irq_ctrl", rd, 32'hA);
        axi_wr(4'h8, 32'h0, 4'hF);
        chk("irq_en_off", irq, 0);
        axi_rd(4'h8, rd); chk("irq_en_off_ctrl", rd, 32'h2);

        axi_wr(4'h0, 32'h0, 4'hF);
        axi_wr(4'h0, 32'hAABBCCDD, 4'b0101);
        axi_rd(4'h0, rd); chk("strb_op_a", rd, 32'h00BB00DD);
        axi_wr(4'hC, 32'hDEADBEEF, 4'hF);
        axi_rd(4'hC, rd); chk("result_ro", rd, 32'h40400000);
        axi_rd(4'h1, rd); chk("addr_lsb_ignored", rd, 32'h00BB00DD);

        @(negedge clk);
        awaddr = 4'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 4'h0; arvalid = 1;
        for (int n = 0; n < 20 && !awready; n++) @(negedge clk);
        chk("par_awready", awready, 1);
        chk("par_arready", arready, 1);
        @(posedge clk); #1;
        held = 1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!bvalid || !rvalid || awready || arready || rdata !== 32'h00BB00DD) held = 0;
        end
        chk("hold_stable", held, 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        chk("hold_bvalid_drop", bvalid, 0);
        chk("hold_rvalid_drop", rvalid, 0);
        axi_rd(4'h4, rd); chk("par_op_b", rd, 32'hCAFEF00D);

        core_lat = 20; core_res = 32'h55555555;
        axi_wr(4'h8, 32'h3, 4'hF);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (30) @(negedge clk);
        chk("rw_irq", irq, 0);
        chk("rw_fpa_a", fpa_a, 0);
        axi_rd(4'h8, rd); chk("rw_ctrl", rd, 0);
        axi_rd(4'hC, rd); chk("rw_result", rd, 0);
        axi_rd(4'h0, rd); chk("rw_op_a", rd, 0);
        axi_rd(4'h4, rd); chk("rw_op_b", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
